// File: rtl/opa_conf_pkg.sv
// opa_conf_pkg: shared types and constants for the OPA/OPB serial configuration loader
package opa_conf_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, PH_A, GAP_A, PH_B, TAIL} state_t;

    // width of the phase down-counter; holds PULSE_W-1 / GAP_W-1 up to 255
    localparam int PH_CW = 8;

    // cycles per serial step: setup gap, phase-A pulse, mid gap, phase-B pulse
    function automatic int step_len(input int p, input int g);
        return 2 * g + 2 * p;
    endfunction

endpackage

// File: rtl/opa_conf_phase_timer.sv
// opa_conf_phase_timer: loadable down-counter flagging the last cycle of a phase
//   CLK   in  clock
//   RESET in  async active-high reset
//   load  in  load len (phase length minus one) on this edge
//   len   in  cycles remaining after the load cycle
//   tc    out terminal count: current cycle is the last of the phase
module opa_conf_phase_timer
    import opa_conf_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [PH_CW-1:0] len,
    output logic             tc
);

    logic [PH_CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (load)
            cnt <= len;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = cnt == '0;

endmodule

// File: rtl/opa_conf_loader.sv
// opa_conf_loader: shifts a parallel frame bit-serially into a two-phase latch chain
//   CLK, RESET        clock, async active-high reset
//   frame_valid/ready host handshake; frame_data captured on accept, bit 0 first
//   abort             stop after the current step (ignored in IDLE and on the last step)
//   CONFin            serial data into the chain, changes only on SETUP entry
//   CONF_CLK, MODE    non-overlapping phase-A / phase-B latch enables
//   CONFout           serial data from the chain tail
//   busy, done, aborted  status; done/aborted are one-cycle pulses
//   rb_data, rb_valid previous chain contents, valid with done
// Optional readback: define OPA_CONF_READBACK_EN; otherwise rb_* are tied low.
module opa_conf_loader
    import opa_conf_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int PULSE_W   = 2,
    parameter int GAP_W     = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [CHAIN_LEN-1:0] frame_data,
    input  logic                 abort,
    output logic                 CONFin,
    output logic                 CONF_CLK,
    output logic                 MODE,
    input  logic                 CONFout,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 rb_valid
);

    localparam int SW = $clog2(CHAIN_LEN);
    localparam logic [PH_CW-1:0] P_LEN = PH_CW'(PULSE_W - 1);
    localparam logic [PH_CW-1:0] G_LEN = PH_CW'(GAP_W - 1);

    state_t               state, state_n;
    logic                 tc, load, last, accept, next_step, finish;
    logic                 abort_q, full;
    logic [SW-1:0]        step;
    logic [CHAIN_LEN-1:0] sr;
    logic [PH_CW-1:0]     len;

    assign accept    = frame_valid & frame_ready;
    assign last      = step == SW'(CHAIN_LEN - 1);
    assign load      = state_n != state;
    assign len       = (state_n == PH_A || state_n == PH_B) ? P_LEN : G_LEN;
    assign next_step = state == PH_B && state_n == SETUP;
    assign finish    = state == TAIL && tc;

    opa_conf_phase_timer u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (load),
        .len   (len),
        .tc    (tc)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_valid) state_n = SETUP;
            SETUP:   if (tc) state_n = PH_A;
            PH_A:    if (tc) state_n = GAP_A;
            GAP_A:   if (tc) state_n = PH_B;
            // the last step always completes; an abort only cuts earlier steps short
            PH_B:    if (tc) state_n = (last || abort_q || abort) ? TAIL : SETUP;
            TAIL:    if (tc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            CONF_CLK    <= 1'b0;
            MODE        <= 1'b0;
            CONFin      <= 1'b0;
            sr          <= '0;
            step        <= '0;
            abort_q     <= 1'b0;
            full        <= 1'b0;
        end else begin
            state       <= state_n;
            frame_ready <= state_n == IDLE;
            busy        <= state_n != IDLE;
            CONF_CLK    <= state_n == PH_A;
            MODE        <= state_n == PH_B;
            done        <= finish && full;
            aborted     <= finish && !full;
            abort_q     <= accept ? 1'b0 : abort_q | (busy & abort);
            if (accept) begin
                sr     <= frame_data;
                CONFin <= frame_data[0];
                step   <= '0;
                full   <= 1'b0;
            end else if (next_step) begin
                // rotate so every frame bit stays live; bit 1 is the next to send
                sr     <= {sr[0], sr[CHAIN_LEN-1:1]};
                CONFin <= sr[1];
                step   <= step + 1'b1;
            end
            if (state == PH_B && tc && last)
                full <= 1'b1;
        end
    end

`ifdef OPA_CONF_READBACK_EN
    logic [CHAIN_LEN-1:0] rb_shift;

    // the tail bit is stable during SETUP, after the previous step's shift settled
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rb_shift <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (state == SETUP && tc)
                rb_shift[step] <= CONFout;
            rb_valid <= finish && full;
            if (finish && full)
                rb_data <= rb_shift;
        end
    end
`else
    logic unused_confout;
    assign unused_confout = CONFout;
    assign rb_data  = '0;
    assign rb_valid = 1'b0;
`endif

endmodule

// File: doc/opa_conf_loader.md
# opa_conf_loader

Serial configuration loader for chains of two-phase latch-configured I/O pass BELs (OPA/OPB style pass-through with per-pin register select). It accepts a parallel configuration frame over a valid/ready handshake and shifts it bit-serially into the chain. It drives the chain's data input, phase-A enable and phase-B enable with guaranteed non-overlapping pulses. It sits between the fabric configuration controller and the tile column's CONFin/CLK/MODE chain.

## Interface
Parameters:
- CHAIN_LEN, 32, number of serial steps per frame (frame width); ≥2.
- PULSE_W, 2, cycles each phase enable is held high; ≥1.
- GAP_W, 1, cycles of all-low separation before/after each pulse; ≥1.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- frame_valid  in  1  host frame offered.
- frame_ready  out  1  loader idle and able to accept.
- frame_data  in  CHAIN_LEN  frame; bit 0 shifted first.
- abort  in  1  request early termination of a running load.
- CONFin  out  1  serial data into chain.
- CONF_CLK  out  1  phase-A latch enable (chain's CLK).
- MODE  out  1  phase-B latch enable (chain's MODE).
- CONFout  in  1  serial data out of chain tail.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse, load completed.
- aborted  out  1  one-cycle pulse, load terminated by abort.
- rb_data  out  CHAIN_LEN  readback frame (OPA_CONF_READBACK_EN only).
- rb_valid  out  1  one-cycle readback strobe (OPA_CONF_READBACK_EN only).

## Operation
- All outputs registered. Reset values: frame_ready=1, all others 0, rb_data=0.
- Accept on edge with frame_valid & frame_ready; frame_data captured into shift register; frame_ready drops, busy rises.
- States: IDLE, SETUP, PH_A, GAP_A, PH_B, TAIL.
- Per step k (0..CHAIN_LEN-1): SETUP (GAP_W cycles, CONFin = frame bit k, enables low) → PH_A (PULSE_W, CONF_CLK=1) → GAP_A (GAP_W, enables low) → PH_B (PULSE_W, MODE=1) → next SETUP, or TAIL after last step.
- CONFin changes only on SETUP entry; never while either enable is high. CONF_CLK and MODE never high in the same cycle.
- TAIL (GAP_W cycles, all low) → IDLE with done=1, frame_ready=1, busy=0.
- After a full load, chain stage s (0 = nearest CONFin) holds frame bit CHAIN_LEN-1-s.
- abort: sampled only while busy; latched. The current step runs to the end of PH_B. Then TAIL, then IDLE with aborted=1 (done=0, rb_valid=0). Abort latched during the final step is ignored; the load completes with done. Abort in IDLE is ignored.
- frame_valid while busy is ignored (not accepted, ready=0).
- RESET mid-load: outputs to reset values immediately; chain contents undefined; host must reload.

## Timing
- Step length S = 2·GAP_W + 2·PULSE_W cycles (default 6).
- Edge 0 = acceptance edge. Step k: SETUP [kS, kS+G), PH_A [kS+G, kS+G+P), GAP_A up to kS+2G+P, PH_B up to (k+1)S.
- TAIL [N·S, N·S+G). done high for cycle N·S+G; defaults: CONF_CLK first high edges 1–3, done at edge 193.
- Back-to-back: new frame acceptable on the done cycle; restart latency 0.

## Configuration
- OPA_CONF_READBACK_EN defined: CONFout sampled at the last SETUP cycle of each step (before PH_A). Bit k → rb_data[k]; rb_data = previous chain contents, deepest stage first. rb_valid pulses with done.
- Undefined: no sample logic; rb_data tied 0, rb_valid tied 0; CONFout unused.

## Structure
- Package opa_conf_pkg: state enum, step-length function S(P,G), phase-count width constant.
- One sub-module opa_conf_phase_timer: loadable down-counter giving terminal-count for PULSE_W/GAP_W phases. FSM, shift register, step counter, readback live in top.

## Test plan
- Defaults, frame 0xA5A5_0F0F → CONFin sequence LSB-first; 32 CONF_CLK and 32 MODE pulses, each 2 cycles; done at edge 193; behavioural chain model holds bit 31 at stage 0.
- Checker on every cycle of random loads → CONF_CLK&MODE never 1; CONFin stable while either enable high.
- abort asserted at edge 40 (step 6) → PH_B of step 6 completes (edge 42); aborted at edge 43; done never pulses; ready=1 at edge 43.
- RESET asserted at edge 100 mid-load → all outputs 0, frame_ready=1 asynchronously; next frame loads correctly from scratch.
- OPA_CONF_READBACK_EN: load 0xFFFF_0000 then 0x1234_5678 → second rb_data = 0xFFFF_0000, rb_valid coincident with done.
- Back-to-back frames with frame_valid held high → second accepted on first done cycle; no gap beyond TAIL.
